wfifo_wr_arbiter: RTL
=====================

// Module: wfifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single write port of the async FIFO
//  (winc/wdata/wfull, write-clock domain) among NREQ requesters.
//  - Grants one requester a burst of up to MAX_BURST words, or fewer if it ends with req_last.
//  - Stalls on wfull; upstream of the FIFO write-pointer/full logic, same clock.
// PARAMETERS
//  NREQ      4   number of requesters (>=2, any integer)
//  DATA_SIZE 8   FIFO word width
//  MAX_BURST 16  max words per grant (>=1)
//  TIMEOUT   8   owner-idle cycles before forced release (only with WARB_IDLE_TIMEOUT_EN)
// PORTS
//  wclk       in   1               write clock, all logic posedge
//  wrst       in   1               synchronous reset, active-high
//  req_valid  in   NREQ            per-requester word valid
//  req_last   in   NREQ            per-requester last-word-of-packet, qualified by valid
//  req_data   in   NREQ*DATA_SIZE  requester i data at [i*DATA_SIZE +: DATA_SIZE]
//  req_ready  out  NREQ            per-requester accept; one-hot or zero
//  wfull      in   1               FIFO full flag (registered in FIFO)
//  winc       out  1               FIFO write strobe
//  wdata      out  DATA_SIZE       FIFO write data
//  busy       out  1               high while in BURST
//  owner      out  ID_W            current owner index; ID_W = max(1,$clog2(NREQ))
// BEHAVIOUR
//  Reset (wrst=1 at posedge):
//  - state=IDLE, rr_ptr=0, owner=0, bcnt=0, idle_cnt=0.
//  - req_ready=0, winc=0, wdata=0, busy=0.
//  - While wrst is high, winc=0 combinationally.
//  - Reset mid-burst abandons the burst; no partial-word recovery.
//  FSM states: IDLE, BURST.
//  IDLE:
//  - No transfers; req_ready=0, winc=0, wdata=0.
//  - If any req_valid: pick first i scanning rr_ptr, rr_ptr+1, ... (mod NREQ).
//  - Next cycle: state=BURST, owner=i, bcnt=0. Arbitration latency 1 cycle.
//  BURST:
//  - req_ready[owner] = ~wfull; all other ready bits 0.
//  - xfer = req_valid[owner] & req_ready[owner]; winc = xfer.
//  - wdata = req_data[owner] slice (0 in IDLE); zero-latency pass-through.
//  - On xfer: bcnt <= bcnt+1.
//  - Release when xfer & (req_last[owner] | bcnt==MAX_BURST-1):
//    next state=IDLE, rr_ptr <= (owner==NREQ-1) ? 0 : owner+1.
//  - Release always costs one IDLE bubble cycle before the next grant.
//  - wfull high: no xfer, bcnt/owner held, grant kept.
//  - Owner valid low (macro off): grant held indefinitely.
//  Other rules:
//  - Non-owner requests wait; no preemption.
//  - Fairness: releasing owner becomes lowest priority.
//  - bcnt width $clog2(MAX_BURST)+1; never exceeds MAX_BURST-1 at release compare.
//  - req_last is ignored unless it coincides with an xfer.
// CONFIGURATION
//  WARB_IDLE_TIMEOUT_EN defined:
//  - In BURST, idle_cnt increments each cycle req_valid[owner]=0; clears on any cycle it is 1.
//  - When idle_cnt reaches TIMEOUT-1 with valid still low: release as above, no winc,
//    rr_ptr advances past owner. idle_cnt cleared on every grant.
//  - wfull stalls with valid high do not count.
//  WARB_IDLE_TIMEOUT_EN undefined:
//  - No idle_cnt logic; TIMEOUT unused; owner releases only on last or MAX_BURST.
// TESTING
//  1. Reset, then req_valid=4'b0100, 3 words, last on 3rd, wfull=0
//     -> 1 IDLE cycle; owner=2; winc high 3 consecutive cycles, data in order; then IDLE, rr_ptr=3.
//  2. All 4 valid continuously, no last, MAX_BURST=16
//     -> grants 0,1,2,3,0 each of exactly 16 winc pulses, one bubble between.
//  3. wfull raised 2 cycles mid-burst of 5
//     -> req_ready/winc low those cycles; burst still totals 5 words; owner unchanged.
//  4. wrst asserted on word 3 of 8 in burst
//     -> next cycle IDLE, busy=0, winc=0, rr_ptr=0; fresh arbitration starts at req 0.
//  5. TIMEOUT=8, macro on: owner 1 drops valid after 2 words
//     -> released after 8 idle cycles with no winc; requester 2 granted next.
//     Macro off: grant held.
//  6. req_last on the 1st word with NREQ=3, owner=2
//     -> single winc; rr_ptr wraps to 0.

Source files
------------

// File: rtl/wfifo_wr_arbiter_if.sv
// wfifo_wr_arbiter_if
//   Bundles the requester-side handshake and the async FIFO write port that the
//   write arbiter sits between.
//   master : the arbiter (drives req_ready, winc, wdata, busy, owner)
//   slave  : the requesters / FIFO side (drives req_valid, req_last, req_data, wfull)
//   Signals:
//     req_valid [NREQ]           per-requester word valid
//     req_last  [NREQ]           per-requester last word of packet
//     req_data  [NREQ*DATA_SIZE] requester i at [i*DATA_SIZE +: DATA_SIZE]
//     req_ready [NREQ]           per-requester accept, one-hot or zero
//     wfull                      FIFO full flag
//     winc                       FIFO write strobe
//     wdata     [DATA_SIZE]      FIFO write data
//     busy                       arbiter is in a burst
//     owner     [ID_W]           current owner index
interface wfifo_wr_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int DATA_SIZE = 8
);
    localparam int ID_W = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_last;
    logic [NREQ*DATA_SIZE-1:0] req_data;
    logic [NREQ-1:0]           req_ready;
    logic                      wfull;
    logic                      winc;
    logic [DATA_SIZE-1:0]      wdata;
    logic                      busy;
    logic [ID_W-1:0]           owner;

    modport master (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata, busy, owner
    );

    modport slave (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata, busy, owner
    );
endinterface

// File: rtl/wfifo_wr_arbiter.sv
// wfifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of the async FIFO among
//   NREQ requesters. A grant lasts until the owner's req_last word or
//   MAX_BURST words, whichever comes first; wfull stalls the burst in place.
//   The releasing owner becomes lowest priority for the next arbitration.
//   Ports:
//     wclk  in  write clock, all logic on posedge
//     wrst  in  synchronous active-high reset
//     bus   wfifo_wr_arbiter_if.master (requester handshake + FIFO write port)
//   Optional feature macro: WARB_IDLE_TIMEOUT_EN
//     When defined, an owner whose valid stays low for TIMEOUT consecutive
//     cycles loses its grant. When undefined an idle owner keeps the grant.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no owner; arbitrate among valid requesters (1 cycle bubble)
//   BURST  | owner holds the write port, words pass straight through
module wfifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 8
) (
    input  logic                     wclk,
    input  logic                     wrst,
    wfifo_wr_arbiter_if.master       bus
);
    localparam int ID_W   = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
    localparam int SUM_W  = ID_W + 1;
    localparam int BCNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

    logic [DATA_SIZE-1:0] data_arr [NREQ];
    logic                 any_valid;
    logic [ID_W-1:0]      pick;
    logic                 xfer;
    logic                 release_grant;
    logic [NREQ-1:0]      ready_c;
    logic                 winc_c;
    logic [DATA_SIZE-1:0] wdata_c;
    logic                 busy_c;

`ifdef WARB_IDLE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign data_arr[g] = bus.req_data[g*DATA_SIZE +: DATA_SIZE];
    end

    // First valid requester scanning rr_ptr, rr_ptr+1, ... wrapping at NREQ.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [ID_W-1:0]  cand;
        any_valid = 1'b0;
        pick      = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NREQ)) begin
                sum = sum - SUM_W'(NREQ);
            end
            cand = sum[ID_W-1:0];
            if (!any_valid && bus.req_valid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        bcnt_d        = bcnt_q;
        ready_c       = '0;
        winc_c        = 1'b0;
        wdata_c       = '0;
        busy_c        = 1'b0;
        xfer          = 1'b0;
        release_grant = 1'b0;
`ifdef WARB_IDLE_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    state_d = S_BURST;
                    owner_d = pick;
                    bcnt_d  = '0;
`ifdef WARB_IDLE_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            S_BURST: begin
                busy_c           = 1'b1;
                ready_c[owner_q] = ~bus.wfull;
                wdata_c          = data_arr[owner_q];
                xfer             = bus.req_valid[owner_q] & ~bus.wfull;
                winc_c           = xfer;
                if (xfer) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bus.req_last[owner_q] || bcnt_q == BCNT_W'(MAX_BURST - 1)) begin
                        release_grant = 1'b1;
                    end
                end
`ifdef WARB_IDLE_TIMEOUT_EN
                // Only cycles with the owner's valid low count as idle; a
                // wfull stall with valid high clears the counter.
                if (!bus.req_valid[owner_q]) begin
                    if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                        release_grant = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
`endif
                if (release_grant) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (owner_q == ID_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are forced quiet during reset, independent of state.
        if (wrst) begin
            ready_c = '0;
            winc_c  = 1'b0;
            wdata_c = '0;
            busy_c  = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            bcnt_q   <= bcnt_d;
        end
    end

`ifdef WARB_IDLE_TIMEOUT_EN
    always_ff @(posedge wclk) begin
        if (wrst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign bus.req_ready = ready_c;
    assign bus.winc      = winc_c;
    assign bus.wdata     = wdata_c;
    assign bus.busy      = busy_c;
    assign bus.owner     = owner_q;
endmodule
